// File: rtl/collision_event_controller.sv
// collision_event_controller: play FSM, collision edge events, lives and power-up timers (optional pause via PAUSE_EN)
module collision_event_controller #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INVULN_CYCLES = 100_000_000,
  parameter int unsigned SPEED_CYCLES  = 300_000_000,
  parameter int unsigned SHIELD_CYCLES = 500_000_000,
  parameter int unsigned TIMER_W       = 32
) (
  input  logic       clock_100mhz,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       is_collision,
  input  logic       is_speed_powerup_collision,
  input  logic       is_shield_powerup_collision,
`ifdef PAUSE_EN
  input  logic       pause,
`endif
  output logic       detector_arm,
  output logic       game_active,
  output logic [3:0] lives_left,
  output logic       invulnerable,
  output logic       shield_active,
  output logic       speed_active,
  output logic       hit_pulse,
  output logic       shield_break_pulse,
  output logic       game_over
);
  typedef enum logic [1:0] {IDLE, ACTIVE, INVULN, OVER} state_t;
  state_t state, state_n;
  logic [TIMER_W-1:0] inv_t, spd_t, shd_t;
  logic col_q, spd_q, shd_q, first, rel;
  logic hold, play, play_n, entering, col_ev, spd_ev, shd_ev, hit_ev, brk_ev;
  assign play = state == ACTIVE || state == INVULN;
  assign play_n = state_n == ACTIVE || state_n == INVULN;
  assign entering = state_n == INVULN && state != INVULN;
`ifdef PAUSE_EN
  assign hold = pause & play;
`else
  assign hold = 1'b0;
`endif
  assign col_ev = is_collision & ~col_q & ~hold;
  assign spd_ev = is_speed_powerup_collision & ~spd_q & ~hold;
  assign shd_ev = is_shield_powerup_collision & ~shd_q & ~hold;
  assign hit_ev = state == ACTIVE && col_ev && !shield_active;
  assign brk_ev = state == ACTIVE && col_ev && shield_active;
  assign game_active = play;
  assign invulnerable = state == INVULN;
  assign game_over = state == OVER;
  assign shield_active = shd_t != '0;
  assign speed_active = spd_t != '0;
  assign detector_arm = ~hold & (state == ACTIVE || (state == INVULN && !first));
  // next-state: a hit with the pre-cycle shield or spare lives costs invulnerability, the last life ends the game
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_btn ? ACTIVE : IDLE;
      ACTIVE:  state_n = col_ev ? ((shield_active || lives_left > 4'd1) ? INVULN : OVER) : ACTIVE;
      INVULN:  state_n = (!hold && inv_t == '0) ? ACTIVE : INVULN;
      OVER:    state_n = (rel && start_btn) ? IDLE : OVER;
      default: state_n = IDLE;
    endcase
  end
  // state, edge registers, lives, pulses and saturating timers
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state <= IDLE;
      lives_left <= '0;
      inv_t <= '0;
      spd_t <= '0;
      shd_t <= '0;
      col_q <= 1'b0;
      spd_q <= 1'b0;
      shd_q <= 1'b0;
      first <= 1'b0;
      rel <= 1'b0;
      hit_pulse <= 1'b0;
      shield_break_pulse <= 1'b0;
    end else begin
      state <= state_n;
      col_q <= is_collision;
      spd_q <= is_speed_powerup_collision;
      shd_q <= is_shield_powerup_collision;
      hit_pulse <= hit_ev;
      shield_break_pulse <= brk_ev;
      first <= entering | (hold & first);
      rel <= state == OVER && (rel || !start_btn);
      lives_left <= (state == IDLE && start_btn) ? 4'(START_LIVES) : hit_ev ? lives_left - 4'd1 : lives_left;
      inv_t <= entering ? TIMER_W'(INVULN_CYCLES - 1) : (state == INVULN && !hold) ? inv_t - TIMER_W'(inv_t != '0) : inv_t;
      spd_t <= !(play && play_n) ? '0 : hold ? spd_t : spd_ev ? TIMER_W'(SPEED_CYCLES) : spd_t - TIMER_W'(spd_t != '0);
      shd_t <= !(play && play_n) ? '0 : hold ? shd_t : shd_ev ? TIMER_W'(SHIELD_CYCLES) : brk_ev ? '0 : shd_t - TIMER_W'(shd_t != '0);
    end
  end
endmodule

// File: tb/tb_collision_event_controller.sv
// tb_collision_event_controller: vector table, directed corner cases and random play against a cycle model
module tb_collision_event_controller;
  localparam int START = 3, INV = 10, SPD = 16, SHD = 20;
  logic clk = 1'b0;
  logic reset, start_btn, is_collision, is_speed_powerup_collision, is_shield_powerup_collision;
  logic detector_arm, game_active, invulnerable, shield_active, speed_active, hit_pulse, shield_break_pulse, game_over;
  logic [3:0] lives_left;
  int checks = 0, failures = 0;
  int ms, ml, minv, mspd, mshd;
  bit mfirst, mrel, mhit, mbrk, pc, ps, psh;
  typedef struct {bit st; bit c; bit s; bit sh; logic [11:0] exp;} vec_t;
  vec_t tv[15];

  collision_event_controller #(.START_LIVES(START), .INVULN_CYCLES(INV), .SPEED_CYCLES(SPD),
                               .SHIELD_CYCLES(SHD), .TIMER_W(32)) dut (
    .clock_100mhz(clk), .reset(reset), .start_btn(start_btn), .is_collision(is_collision),
    .is_speed_powerup_collision(is_speed_powerup_collision),
    .is_shield_powerup_collision(is_shield_powerup_collision),
`ifdef PAUSE_EN
    .pause(1'b0),
`endif
    .detector_arm(detector_arm), .game_active(game_active), .lives_left(lives_left),
    .invulnerable(invulnerable), .shield_active(shield_active), .speed_active(speed_active),
    .hit_pulse(hit_pulse), .shield_break_pulse(shield_break_pulse), .game_over(game_over));

  always #5 clk = ~clk;

  function automatic logic [11:0] o(bit arm, bit gact, logic [3:0] lv, bit inv, bit shd, bit spd, bit hit, bit brk, bit over);
    return {arm, gact, lv, inv, shd, spd, hit, brk, over};
  endfunction

  function automatic logic [11:0] dut_out();
    return {detector_arm, game_active, lives_left, invulnerable, shield_active, speed_active, hit_pulse, shield_break_pulse, game_over};
  endfunction

  // model phases: 0 idle, 1 playing, 2 invulnerable, 3 game over; timers hold remaining cycles
  function automatic logic [11:0] mexp();
    return o(ms == 1 || (ms == 2 && !mfirst), ms == 1 || ms == 2, 4'(ml), ms == 2, mshd > 0, mspd > 0, mhit, mbrk, ms == 3);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(bit r, bit st, bit c, bit s, bit sh);
    bit ec, es, esh, hit, brk;
    int ns;
    if (r) begin
      ms = 0; ml = 0; minv = 0; mspd = 0; mshd = 0;
      mfirst = 0; mrel = 0; mhit = 0; mbrk = 0; pc = 0; ps = 0; psh = 0;
    end else begin
      ec = c && !pc; es = s && !ps; esh = sh && !psh;
      hit = 0; brk = 0; ns = ms;
      case (ms)
        0: if (st) begin ns = 1; ml = START; end
        1: if (ec) begin
             if (mshd > 0) begin brk = 1; mshd = 0; end
             else begin hit = 1; ml = ml - 1; end
             ns = ml > 0 ? 2 : 3;
           end
        2: begin minv = minv - 1; if (minv == 0) ns = 1; end
        default: if (mrel && st) ns = 0;
      endcase
      if (ns == 2 && ms != 2) minv = INV;
      if ((ms == 1 || ms == 2) && (ns == 1 || ns == 2)) begin
        mspd = es ? SPD : (mspd > 0 ? mspd - 1 : 0);
        mshd = esh ? SHD : (mshd > 0 ? mshd - 1 : 0);
      end else begin
        mspd = 0; mshd = 0;
      end
      mfirst = ns == 2 && ms != 2;
      mrel = ms == 3 && (mrel || !st);
      mhit = hit; mbrk = brk; ms = ns;
      pc = c; ps = s; psh = sh;
    end
  endtask

  task automatic step(bit r, bit st, bit c, bit s, bit sh);
    reset = r; start_btn = st; is_collision = c;
    is_speed_powerup_collision = s; is_shield_powerup_collision = sh;
    @(posedge clk);
    model_step(r, st, c, s, sh);
    #1;
    chk("model", dut_out(), mexp());
  endtask

  task automatic restart();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    bit rc, rs, rsh;
    tv[0]  = '{1, 0, 0, 0, o(1, 1, 3, 0, 0, 0, 0, 0, 0)};
    tv[1]  = '{0, 0, 0, 0, o(1, 1, 3, 0, 0, 0, 0, 0, 0)};
    tv[2]  = '{0, 1, 0, 0, o(0, 1, 2, 1, 0, 0, 1, 0, 0)};
    tv[3]  = '{0, 1, 0, 0, o(1, 1, 2, 1, 0, 0, 0, 0, 0)};
    tv[4]  = '{0, 0, 0, 0, o(1, 1, 2, 1, 0, 0, 0, 0, 0)};
    tv[5]  = '{0, 1, 0, 0, o(1, 1, 2, 1, 0, 0, 0, 0, 0)};
    for (int i = 6; i < 12; i++) tv[i] = '{0, 0, 0, 0, o(1, 1, 2, 1, 0, 0, 0, 0, 0)};
    tv[12] = '{0, 0, 0, 0, o(1, 1, 2, 0, 0, 0, 0, 0, 0)};
    tv[13] = '{0, 0, 1, 0, o(1, 1, 2, 0, 0, 1, 0, 0, 0)};
    tv[14] = '{0, 0, 0, 1, o(1, 1, 2, 0, 1, 1, 0, 0, 0)};
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset", dut_out(), 0);
    for (int i = 0; i < 15; i++) begin
      step(0, tv[i].st, tv[i].c, tv[i].s, tv[i].sh);
      chk($sformatf("vec%0d", i), dut_out(), tv[i].exp);
    end
    restart();
    step(0, 0, 0, 0, 1);
    chk("shield_on", shield_active, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("brk_pulse", shield_break_pulse, 1);
    chk("brk_no_hit", hit_pulse, 0);
    chk("brk_lives", lives_left, 3);
    chk("brk_shield_off", shield_active, 0);
    chk("brk_invuln", invulnerable, 1);
    chk("brk_disarm", detector_arm, 0);
    step(0, 0, 1, 0, 0);
    chk("brk_pulse_end", shield_break_pulse, 0);
    chk("rearm", detector_arm, 1);
    restart();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("speed_repick", speed_active, 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      if (speed_active) cnt++;
    end
    chk("speed_len", cnt, 16);
    chk("speed_off", speed_active, 0);
    restart();
    for (int h = 0; h < 2; h++) begin
      step(0, 0, 1, 0, 0);
      chk("hit_lives", lives_left, 4'(2 - h));
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("invuln_done", invulnerable, 0);
      chk("active_again", game_active, 1);
    end
    step(0, 1, 1, 0, 0);
    chk("last_hit", hit_pulse, 1);
    chk("over_lives", lives_left, 0);
    chk("over_flag", game_over, 1);
    chk("over_disarm", detector_arm, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("held_start", game_over, 1);
    step(0, 0, 0, 0, 0);
    chk("released", game_over, 1);
    step(0, 1, 0, 0, 0);
    chk("to_idle", {game_over, game_active}, 0);
    step(0, 1, 0, 0, 0);
    chk("restart_active", game_active, 1);
    chk("restart_lives", lives_left, 3);
    restart();
    step(0, 0, 1, 0, 1);
    chk("sim_hit", hit_pulse, 1);
    chk("sim_lives", lives_left, 2);
    chk("sim_shield", shield_active, 1);
    chk("sim_invuln", invulnerable, 1);
    step(0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("reset_invuln", dut_out(), 0);
    rc = 0; rs = 0; rsh = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) rc = ~rc;
      if ($urandom_range(5) == 0) rs = ~rs;
      if ($urandom_range(5) == 0) rsh = ~rsh;
      step($urandom_range(499) == 0, $urandom_range(3) == 0, rc, rs, rsh);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
